dram_resp: RTL
==============

Name: dram_resp

Overview:
- Data-memory responder for the CPU core's data port. It receives address, write data, read/write enables and funct3-style size from the EX stage, and performs byte-lane stores.
- It returns load data aligned and sign- or zero-extended, one cycle after the access is accepted, for the MEM stage.
- It can insert programmable wait states by driving a hold flag back into the core's pipeline-hold input.

Parameters:
- DEPTH_WORDS, 4096, number of 32-bit words stored; must be a power of two. Word index is addr_i[$clog2(DEPTH_WORDS)+1:2]; higher address bits are ignored and alias.
- WAIT_CYCLES, 0, hold cycles inserted before each access; range 0..255.

Ports:
- clk  in  1  system clock.
- rst  in  1  one clock; reset is asynchronous and active-low.
- addr_i  in  32  byte address from the core.
- data_i  in  32  store data from the core.
- we_i  in  1  write request.
- re_i  in  1  read request.
- size_i  in  3  access size. 000 = B, 001 = H, 010 = W, 100 = BU, 101 = HU; BU/HU apply to reads only.
- data_o  out  32  load data to the core, extended and right-aligned.
- hold_flag_o  out  1  stall request to the core.
- err_o  out  1  one-cycle pulse on a misaligned or illegal-size access.

Behaviour:
- Request: req = we_i | re_i. If both we_i and re_i are 1, the write takes priority and the read is ignored; data_o keeps its value.
- Reset state (rst = 0, asynchronous):
  - FSM = IDLE, wait counter = 0.
  - data_o = 0, hold_flag_o = 0, err_o = 0.
  - Memory contents are not cleared.
- FSM has 2 states, IDLE and WAIT.
  - IDLE, req = 1, WAIT_CYCLES > 0: hold_flag_o = 1 combinationally; cnt <= WAIT_CYCLES-1; next state WAIT. No access is performed.
  - IDLE, req = 1, WAIT_CYCLES = 0: the access is performed at this clock edge; hold_flag_o = 0; stay in IDLE.
  - WAIT, cnt != 0: hold_flag_o = 1; cnt <= cnt-1.
  - WAIT, cnt = 0: hold_flag_o = 0; the access is performed at this edge; next state IDLE.
  - Net effect: each access sees exactly WAIT_CYCLES hold cycles, and the access executes on the first cycle with hold low.
  - The core keeps addr_i, data_i and the controls stable while hold_flag_o = 1. If req drops while in WAIT, the FSM returns to IDLE with no access.
- Legal sizes and alignment:
  - Legal sizes: 000 and 100 at any address; 001 and 101 with addr_i[0] = 0; 010 with addr_i[1:0] = 0.
  - Stores accept only 000, 001 and 010. All other codes are illegal.
- Store, performed at the edge:
  - B: writes data_i[7:0] to byte lane addr_i[1:0].
  - H: writes data_i[15:0] to lanes {addr_i[1],0} and {addr_i[1],1}.
  - W: writes the whole word.
  - Untouched lanes keep their value.
- Load, performed at the edge: data_o is registered from the current memory contents (old data if a write to the same word happened in an earlier cycle; no same-edge write exists).
  - B/BU: the lane byte, sign-extended (B) or zero-extended (BU).
  - H/HU: the selected halfword, sign-extended (H) or zero-extended (HU).
  - W: the whole word.
  - data_o holds its value until the next load completes.
  - Latency: data_o is valid on the cycle after the access edge.
- Misaligned or illegal-size access:
  - The wait states still elapse.
  - At the access edge: no memory write, data_o <= 0, err_o = 1 for exactly one cycle.
  - Otherwise err_o = 0.
- Reset asserted mid-WAIT: the FSM aborts to IDLE immediately and no write occurs.

Optional Feature:
- Macro DRAM_RESP_PERF_CNT_EN.
- When defined, two extra outputs exist: rd_cnt_o[31:0] and wr_cnt_o[31:0].
  - Each increments by 1 at every successful (legal) load or store access edge.
  - Both reset to 0 and wrap from 0xFFFFFFFF to 0.
  - Illegal or aborted accesses are not counted.
- When undefined, the ports and counters are absent and there is no other behavioural change.

Test Plan:
- WAIT_CYCLES = 0: store W 0xDEADBEEF to 0x100, then load W from 0x100 → data_o = 0xDEADBEEF one cycle after the load; hold_flag_o stays 0 throughout.
- Store B 0x80 to 0x101, then load B from 0x101 → 0xFFFFFF80. Load BU from 0x101 → 0x00000080. Load W from 0x100 → 0xDEAD80EF.
- Load H from 0x102 holding 0xDEAD → 0xFFFFDEAD; load HU from 0x102 → 0x0000DEAD. Load W from 0x102 → err_o pulses 1 cycle, data_o = 0, memory unchanged.
- WAIT_CYCLES = 3: store request → hold_flag_o high exactly 3 cycles, the write commits on the 4th edge, and a follow-up load returns the stored value.
- WAIT_CYCLES = 3, rst pulled low during the 2nd hold cycle → hold_flag_o = 0 immediately, the target word is unchanged, and after release the FSM is in IDLE.
- DRAM_RESP_PERF_CNT_EN defined: 5 legal loads, 2 legal stores and 1 misaligned store → rd_cnt_o = 5, wr_cnt_o = 2.

Source files
------------

// File: rtl/dram_resp.sv
// rtl/dram_resp.sv - data-memory responder: byte-lane stores, extended loads, programmable wait states
// Optional feature macro: DRAM_RESP_PERF_CNT_EN (adds rd_cnt_o / wr_cnt_o access counters)
module dram_resp #(
  parameter int DEPTH_WORDS = 4096,
  parameter int WAIT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr_i,
  input  logic [31:0] data_i,
  input  logic        we_i,
  input  logic        re_i,
  input  logic [2:0]  size_i,
  output logic [31:0] data_o,
  output logic        hold_flag_o,
  output logic        err_o
`ifdef DRAM_RESP_PERF_CNT_EN
  ,
  output logic [31:0] rd_cnt_o,
  output logic [31:0] wr_cnt_o
`endif
);

  localparam int         AW       = $clog2(DEPTH_WORDS);
  localparam bit         HAS_WAIT = (WAIT_CYCLES > 0);
  localparam logic [7:0] CNT_INIT = HAS_WAIT ? 8'(WAIT_CYCLES - 1) : 8'd0;

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t      state, state_nxt;
  logic [7:0]  cnt, cnt_nxt;
  logic        req;
  logic        go;
  logic        legal;
  logic        is_load;
  logic [AW-1:0] idx;
  logic [31:0] mem [DEPTH_WORDS];
  logic [31:0] rword;
  logic [7:0]  rbyte;
  logic [15:0] rhalf;
  logic [31:0] load_val;
  logic [31:0] wdata;
  logic [3:0]  be;
  logic        unused_addr;

  // Write wins when both enables are set; the read side is then ignored.
  assign req     = we_i | re_i;
  assign is_load = re_i & ~we_i;
  assign idx     = addr_i[AW+1:2];
  // Address bits above the array alias and are deliberately ignored.
  assign unused_addr = ^addr_i[31:AW+2];

  // Size/alignment legality; unsigned sizes are load-only.
  always_comb begin
    legal = 1'b0;
    case (size_i)
      3'b000:  legal = 1'b1;
      3'b001:  legal = ~addr_i[0];
      3'b010:  legal = (addr_i[1:0] == 2'b00);
      3'b100:  legal = ~we_i;
      3'b101:  legal = ~we_i & ~addr_i[0];
      default: legal = 1'b0;
    endcase
  end

  // State and wait counter; reset aborts any pending wait.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
      cnt   <= 8'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state: count down the hold cycles, bail out if the request vanishes.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      S_IDLE: begin
        if (req && HAS_WAIT) begin
          state_nxt = S_WAIT;
          cnt_nxt   = CNT_INIT;
        end
      end
      S_WAIT: begin
        if (!req)
          state_nxt = S_IDLE;
        else if (cnt != 8'd0)
          cnt_nxt = cnt - 8'd1;
        else
          state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Outputs: hold while waits remain, fire the access on the first unheld cycle.
  always_comb begin
    hold_flag_o = 1'b0;
    go          = 1'b0;
    case (state)
      S_IDLE: begin
        hold_flag_o = rst & req & HAS_WAIT;
        go          = rst & req & ~HAS_WAIT;
      end
      S_WAIT: begin
        hold_flag_o = rst & req & (cnt != 8'd0);
        go          = rst & req & (cnt == 8'd0);
      end
      default: ;
    endcase
  end

  // Store lane enables and replicated write data.
  always_comb begin
    be    = 4'b0000;
    wdata = data_i;
    case (size_i[1:0])
      2'b00: begin
        be    = 4'b0001 << addr_i[1:0];
        wdata = {4{data_i[7:0]}};
      end
      2'b01: begin
        be    = addr_i[1] ? 4'b1100 : 4'b0011;
        wdata = {2{data_i[15:0]}};
      end
      default: be = 4'b1111;
    endcase
  end

  // Load path: pick lane, then sign- or zero-extend.
  always_comb begin
    rword    = mem[idx];
    rbyte    = rword[8*addr_i[1:0] +: 8];
    rhalf    = addr_i[1] ? rword[31:16] : rword[15:0];
    load_val = rword;
    case (size_i)
      3'b000:  load_val = {{24{rbyte[7]}}, rbyte};
      3'b100:  load_val = {24'd0, rbyte};
      3'b001:  load_val = {{16{rhalf[15]}}, rhalf};
      3'b101:  load_val = {16'd0, rhalf};
      default: load_val = rword;
    endcase
  end

  // Memory array is never cleared; only legal stores at the access edge write.
  always_ff @(posedge clk) begin
    if (go && legal && we_i) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  // Registered load data and one-cycle error pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_o <= 32'd0;
      err_o  <= 1'b0;
    end else begin
      err_o <= go & ~legal;
      if (go) begin
        if (!legal)       data_o <= 32'd0;
        else if (is_load) data_o <= load_val;
      end
    end
  end

`ifdef DRAM_RESP_PERF_CNT_EN
  // Count only legal completed accesses; counters wrap naturally.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_cnt_o <= 32'd0;
      wr_cnt_o <= 32'd0;
    end else if (go && legal) begin
      if (we_i) wr_cnt_o <= wr_cnt_o + 32'd1;
      else      rd_cnt_o <= rd_cnt_o + 32'd1;
    end
  end
`endif

endmodule
